// File: rtl/cnn_pkg.sv
// cnn_pkg: shared geometry and pixel/window types for the conv window generator
package cnn_pkg;
  localparam int DATA_W = 8;
  localparam int IMG_W = 27;
  localparam int IMG_H = 27;
  localparam int K = 3;
  localparam int RW = $clog2(IMG_H);
  localparam int CW = $clog2(IMG_W);
  typedef logic [DATA_W-1:0] pixel_t;
  typedef pixel_t [K*K-1:0] window_t;
endpackage

// File: rtl/conv_window_gen_line_buffer.sv
// line_buffer: enable-gated shift register delaying pixels by one image row
module line_buffer #(
  parameter int DATA_W = 8,
  parameter int DEPTH = 27
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en_i,
  input  logic [DATA_W-1:0] d_i,
  output logic [DATA_W-1:0] q_o
);
  logic [DATA_W-1:0] sr_q [DEPTH];
  // shift one entry per enabled cycle; output is the entry pushed DEPTH shifts ago
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int n = 0; n < DEPTH; n++) sr_q[n] <= '0;
    end else if (en_i) begin
      sr_q[0] <= d_i;
      for (int n = 1; n < DEPTH; n++) sr_q[n] <= sr_q[n-1];
    end
  end
  assign q_o = sr_q[DEPTH-1];
endmodule

// File: rtl/conv_window_gen.sv
// conv_window_gen: builds KxK sliding windows from a raster pixel stream
module conv_window_gen
  import cnn_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  feat_valid,
  input  logic [DATA_W-1:0]     feat_data,
  output logic                  feat_rd_en,
  output logic                  win_valid,
  input  logic                  win_ready,
  output logic [K*K*DATA_W-1:0] win_data,
  output logic [RW-1:0]         win_row,
  output logic [CW-1:0]         win_col,
  output logic                  frame_done
);
  logic [RW-1:0] row_q, row_d, win_row_q, win_row_d;
  logic [CW-1:0] col_q, col_d, win_col_q, win_col_d;
  window_t win_q, win_d;
  logic win_valid_q, win_valid_d, frame_done_q, frame_done_d;
  logic pop, at_win, col_end, row_end;
  pixel_t lb_in [K];
  pixel_t lb_out [K-1];
  assign pop = feat_valid && (!win_valid_q || win_ready);
  assign at_win = (row_q >= RW'(K-1)) && (col_q >= CW'(K-1));
  assign col_end = col_q == CW'(IMG_W-1);
  assign row_end = row_q == RW'(IMG_H-1);
  assign lb_in[0] = feat_data;
  genvar i;
  generate
    for (i = 0; i < K-1; i++) begin : g_lb
      line_buffer #(.DATA_W(DATA_W), .DEPTH(IMG_W)) u_lb (
        .clk  (clk),
        .rst_n(rst_n),
        .en_i (pop),
        .d_i  (lb_in[i]),
        .q_o  (lb_out[i])
      );
      assign lb_in[i+1] = lb_out[i];
    end
  endgenerate
  // slide the window left and insert the new column: top row from the oldest line buffer
  always_comb begin
    win_d = win_q;
    if (pop) begin
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K-1; c++) win_d[r*K+c] = win_q[r*K+c+1];
        win_d[r*K+K-1] = lb_in[K-1-r];
      end
    end
  end
  // raster counters, output handshake and end-of-frame detection
  always_comb begin
    col_d = pop ? (col_end ? '0 : col_q + CW'(1)) : col_q;
    row_d = (pop && col_end) ? (row_end ? '0 : row_q + RW'(1)) : row_q;
    win_valid_d = (pop && at_win) ? 1'b1 : (win_ready ? 1'b0 : win_valid_q);
    win_row_d = (pop && at_win) ? row_q - RW'(K-1) : win_row_q;
    win_col_d = (pop && at_win) ? col_q - CW'(K-1) : win_col_q;
    frame_done_d = win_valid_q && win_ready && (win_row_q == RW'(IMG_H-K)) && (win_col_q == CW'(IMG_W-K));
  end
  // state registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      row_q <= '0;
      col_q <= '0;
      win_q <= '0;
      win_valid_q <= 1'b0;
      win_row_q <= '0;
      win_col_q <= '0;
      frame_done_q <= 1'b0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
      win_q <= win_d;
      win_valid_q <= win_valid_d;
      win_row_q <= win_row_d;
      win_col_q <= win_col_d;
      frame_done_q <= frame_done_d;
    end
  end
  assign feat_rd_en = pop;
  assign win_valid = win_valid_q;
  assign win_data = win_q;
  assign win_row = win_row_q;
  assign win_col = win_col_q;
  assign frame_done = frame_done_q;
endmodule

// File: tb/tb_conv_window_gen.sv
// tb_conv_window_gen: randomized stream checked against a frame-image reference model
module tb_conv_window_gen;
  import cnn_pkg::*;
  localparam logic [K*K*DATA_W-1:0] FIRST_WIN = {8'd56, 8'd55, 8'd54, 8'd29, 8'd28, 8'd27, 8'd2, 8'd1, 8'd0};
  localparam logic [K*K*DATA_W-1:0] LAST_WIN = {8'd216, 8'd215, 8'd214, 8'd189, 8'd188, 8'd187, 8'd162, 8'd161, 8'd160};
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic feat_valid = 1'b0;
  logic win_ready = 1'b0;
  logic [DATA_W-1:0] feat_data = '0;
  logic feat_rd_en, win_valid, frame_done;
  logic [K*K*DATA_W-1:0] win_data;
  logic [RW-1:0] win_row;
  logic [CW-1:0] win_col;
  typedef struct {
    logic [K*K*DATA_W-1:0] d;
    int r;
    int c;
  } exp_t;
  exp_t exp_q[$];
  pixel_t img [IMG_H][IMG_W];
  int mr, mc, n_checks, n_errs, n_seen, n_fd;
  logic fd_exp, held_v, got_first, pat_mode;
  logic [K*K*DATA_W-1:0] held, first_d, last_d;
  always #5 clk = ~clk;
  conv_window_gen dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .feat_valid(feat_valid),
    .feat_data (feat_data),
    .feat_rd_en(feat_rd_en),
    .win_valid (win_valid),
    .win_ready (win_ready),
    .win_data  (win_data),
    .win_row   (win_row),
    .win_col   (win_col),
    .frame_done(frame_done)
  );
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic pixel_t pat(input int p);
    return pixel_t'(p % 256);
  endfunction
  task automatic cycle(input logic v, input logic rdy, input pixel_t d);
    exp_t e;
    logic exp_v;
    @(negedge clk);
    feat_valid = v;
    win_ready = rdy;
    feat_data = d;
    #1;
    exp_v = exp_q.size() != 0;
    check("win_valid", win_valid, exp_v);
    check("frame_done", frame_done, fd_exp);
    if (frame_done) n_fd++;
    check("rd_en", feat_rd_en, v && (!exp_v || rdy));
    if (held_v && exp_v) check("hold", win_data, held);
    fd_exp = 1'b0;
    if (win_valid && rdy) n_seen++;
    if (exp_v && rdy) begin
      e = exp_q.pop_front();
      check("win_data", win_data, e.d);
      check("win_row", win_row, e.r);
      check("win_col", win_col, e.c);
      if (pat_mode && e.r == 1 && e.c == 0) check("wrap_slot0", win_data[DATA_W-1:0], 27);
      if (!got_first) first_d = win_data;
      got_first = 1'b1;
      last_d = win_data;
      fd_exp = (e.r == IMG_H-K) && (e.c == IMG_W-K);
    end
    held_v = exp_v && !rdy;
    held = win_data;
    if (v && (!exp_v || rdy)) begin
      img[mr][mc] = d;
      if (mr >= K-1 && mc >= K-1) begin
        for (int r = 0; r < K; r++)
          for (int c = 0; c < K; c++)
            e.d[(r*K+c)*DATA_W +: DATA_W] = img[mr-K+1+r][mc-K+1+c];
        e.r = mr - K + 1;
        e.c = mc - K + 1;
        exp_q.push_back(e);
      end
      mc++;
      if (mc == IMG_W) begin
        mc = 0;
        mr = (mr + 1) % IMG_H;
      end
    end
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    feat_valid = 1'b0;
    win_ready = 1'b0;
    @(negedge clk);
    #1;
    check("rst_valid", win_valid, 0);
    check("rst_done", frame_done, 0);
    check("rst_data", win_data, 0);
    check("rst_row", win_row, 0);
    check("rst_col", win_col, 0);
    check("rst_rd_en", feat_rd_en, 0);
    rst_n = 1'b1;
    exp_q.delete();
    mr = 0;
    mc = 0;
    fd_exp = 1'b0;
    held_v = 1'b0;
    got_first = 1'b0;
    first_d = '0;
  endtask
  initial begin
    n_checks = 0;
    n_errs = 0;
    pat_mode = 1'b1;
    do_reset();
    n_seen = 0;
    n_fd = 0;
    for (int p = 0; p < IMG_W*IMG_H; p++) cycle(1'b1, 1'b1, pat(p));
    cycle(1'b0, 1'b1, '0);
    cycle(1'b0, 1'b1, '0);
    check("first_win", first_d, FIRST_WIN);
    check("last_win", last_d, LAST_WIN);
    check("n_windows", n_seen, (IMG_H-K+1)*(IMG_W-K+1));
    check("n_frame_done", n_fd, 1);
    do_reset();
    begin
      int p;
      logic t;
      p = 0;
      t = 1'b1;
      while (p < 80) begin
        cycle(t, 1'b1, t ? pat(p) : 8'hEE);
        if (t) p++;
        t = !t;
      end
      check("toggle_first_win", first_d, FIRST_WIN);
      for (int s = 0; s < 5; s++) cycle(1'b1, 1'b0, pat(p));
      for (int s = 0; s < 20; s++) cycle(1'b1, 1'b1, pat(p + s));
    end
    pat_mode = 1'b0;
    n_fd = 0;
    for (int s = 0; s < 3500; s++)
      cycle($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6, pixel_t'($urandom));
    for (int s = 0; s < 4; s++) cycle(1'b0, 1'b1, '0);
    check("rand_drained", exp_q.size(), 0);
    pat_mode = 1'b1;
    do_reset();
    for (int p = 0; p <= 300; p++) cycle(1'b1, 1'b1, pat(p));
    do_reset();
    for (int p = 0; p < 60; p++) cycle(1'b1, 1'b1, pat(p));
    check("restart_first_win", first_d, FIRST_WIN);
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end
endmodule
